// File: rtl/instr_fetch_stage.sv
// Fetch stage: owns the PC, addresses program memory and loads the IF/ID register.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module instr_fetch_stage #(
    parameter int unsigned             DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]   RESET_PC   = DATA_WIDTH'(32'h0040_0000),
    parameter logic [DATA_WIDTH-1:0]   NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_instr_i,
    output logic [DATA_WIDTH-1:0] if_id_pc_o,
    output logic [DATA_WIDTH-1:0] if_id_pc_plus4_o,
    output logic [DATA_WIDTH-1:0] if_id_instr_o,
    output logic                  if_id_valid_o,
    output logic [31:0]           fetch_cnt_o,
    output logic [31:0]           bubble_cnt_o
);

    localparam int unsigned CNT_W = 32;

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] id_pc_q, id_pc_d;
    logic [DATA_WIDTH-1:0] id_pc4_q, id_pc4_d;
    logic [DATA_WIDTH-1:0] id_instr_q, id_instr_d;
    logic                  id_valid_q, id_valid_d;
    logic [DATA_WIDTH-1:0] pc_plus4_c;
    logic                  advance_c;
    logic                  bubble_c;

    assign pc_plus4_c = pc_q + DATA_WIDTH'(4);
    assign advance_c  = !redirect_i && !stall_i;
    assign bubble_c   = redirect_i || stall_i;

    // Next-state: redirect beats stall beats advance
    always_comb begin
        pc_d       = pc_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        id_instr_d = id_instr_q;
        id_valid_d = id_valid_q;
        if (redirect_i) begin
            pc_d       = redirect_pc_i & ~DATA_WIDTH'(3);
            id_pc_d    = '0;
            id_pc4_d   = '0;
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
        end else if (!stall_i) begin
            pc_d       = pc_plus4_c;
            id_pc_d    = pc_q;
            id_pc4_d   = pc_plus4_c;
            id_instr_d = imem_instr_i;
            id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            id_pc_q    <= '0;
            id_pc4_q   <= '0;
            id_instr_q <= NOP_INSTR;
            id_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_instr_q <= id_instr_d;
            id_valid_q <= id_valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating event counters
    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (advance_c && (fetch_cnt_q != '1)) begin
            fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
        end
        if (bubble_c && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_cnt_o  = fetch_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`else
    logic unused_ev_c;
    assign unused_ev_c  = advance_c ^ bubble_c;
    assign fetch_cnt_o  = CNT_W'(0);
    assign bubble_cnt_o = CNT_W'(0);
`endif

    assign imem_addr_o      = pc_q;
    assign if_id_pc_o       = id_pc_q;
    assign if_id_pc_plus4_o = id_pc4_q;
    assign if_id_instr_o    = id_instr_q;
    assign if_id_valid_o    = id_valid_q;

endmodule

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

Fetch stage of the 5-stage RISC-V pipeline: owns the program counter, drives the address port of the program memory (combinational ROM, code segment based at 0x00400000), and captures the returned instruction into the IF/ID pipeline register. It applies hazard-unit stalls and EX-stage branch/jump redirects, and inserts NOP bubbles on flush.

## Interface
Parameters:
- DATA_WIDTH, 32, width of PC, address and instruction
- RESET_PC, 32'h00400000, PC value after reset (start of code segment)
- NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- stall_i  in  1  hazard unit: hold PC and IF/ID (load-use)
- redirect_i  in  1  taken branch/jump resolved in EX
- redirect_pc_i  in  DATA_WIDTH  redirect target address
- imem_addr_o  out  DATA_WIDTH  address to program memory
- imem_instr_i  in  DATA_WIDTH  instruction from program memory (same-cycle)
- if_id_pc_o  out  DATA_WIDTH  PC of instruction in IF/ID
- if_id_pc_plus4_o  out  DATA_WIDTH  that PC + 4 (link value)
- if_id_instr_o  out  DATA_WIDTH  instruction in IF/ID
- if_id_valid_o  out  1  IF/ID holds a real fetched instruction
- fetch_cnt_o  out  32  perf: instructions loaded into IF/ID
- bubble_cnt_o  out  32  perf: stall + flush cycles

## Operation
- State: pc register; IF/ID register {pc, pc_plus4, instr, valid}.
- imem_addr_o = pc register directly; no combinational path from any input.
- Per-edge priority: reset > redirect > stall > advance.
- reset: pc <= RESET_PC; if_id_pc <= 0; if_id_pc_plus4 <= 0; if_id_instr <= NOP_INSTR; if_id_valid <= 0; counters <= 0.
- redirect (overrides stall): pc <= {redirect_pc_i[31:2], 2'b00}; IF/ID <= {0, 0, NOP_INSTR, 0}. Instruction currently on imem_instr_i discarded.
- stall (no redirect): pc and all IF/ID fields hold.
- advance: pc <= pc + 4 (mod 2^32, wraps 0xFFFFFFFC -> 0); IF/ID <= {pc, pc + 4, imem_instr_i, 1}.
- Adder is DATA_WIDTH bits, carry dropped. Low two PC bits always 00.
- No address range check; out-of-range fetch returns whatever memory returns.

## Timing
- Fetch latency: address presented in cycle n, instruction visible on if_id_* in cycle n+1.
- First cycle after reset deasserts: imem_addr_o = 0x00400000; first valid IF/ID in the following cycle.
- Redirect asserted in cycle n: cycle n+1 imem_addr_o = target and if_id_valid_o = 0; cycle n+2 IF/ID holds target instruction, valid = 1. One bubble.
- Stall held k cycles: IF/ID and imem_addr_o constant for k cycles; advance resumes on first cycle with stall_i = 0.
- reset asserted mid-stream (including during stall/redirect): all state takes reset values on that edge.

## Configuration
- FETCH_PERF_CNT_EN defined: fetch_cnt_o increments on every advance edge; bubble_cnt_o increments on every redirect or stall edge (not reset); both saturate at 32'hFFFFFFFF; both cleared by reset.
- Not defined: counter registers not built; fetch_cnt_o and bubble_cnt_o tied to 0. All other behaviour identical.

## Test plan
- Reset then 4 free-running cycles with memory returning 0x100+addr[7:0] -> imem_addr_o 0x00400000, ..04, ..08, ..0C; if_id_pc_o lags by one cycle, if_id_pc_plus4_o = pc + 4, valid = 1 from cycle 2.
- stall_i high 3 cycles at pc 0x00400008 -> imem_addr_o and IF/ID frozen 3 cycles, then advance to 0x0040000C; bubble_cnt_o = 3 (macro on), 0 (macro off).
- redirect_i with redirect_pc_i = 0x00400043 -> next cycle imem_addr_o = 0x00400040, if_id_instr_o = 0x00000013, valid = 0; following cycle valid = 1, if_id_pc_o = 0x00400040.
- redirect_i and stall_i together to 0x00400020 -> redirect wins; next cycle imem_addr_o = 0x00400020, IF/ID bubble.
- PC preset via redirect to 0xFFFFFFFC then advance -> imem_addr_o = 0x00000000, if_id_pc_plus4_o = 0x00000000.
- reset asserted during stall with pc 0x00400010 -> next cycle imem_addr_o = 0x00400000, if_id_valid_o = 0, counters 0.
